// File: rtl/div_unit.sv
// div_unit: multi-cycle RV32M divider for the EX stage (DIV, DIVU, REM, REMU).
//
// State | meaning
// IDLE  | waiting for an accepted divide op
// CALC  | restoring division, one quotient bit per cycle (busy high)
// DONE  | result valid for one cycle (done high)
//
// Ports:
//   clk        clock
//   rst        synchronous, active-high reset
//   start      ID/EX holds a valid M-extension divide op this cycle
//   funct3     100 DIV, 101 DIVU, 110 REM, 111 REMU; other codes ignored
//   rs1_value  dividend
//   rs2_value  divisor
//   flush      abandon any in-flight op (taken branch / jump)
//   busy       high while in CALC; stalls PC, IF/ID and ID/EX
//   done       one-cycle pulse, result valid
//   result     quotient or remainder, held until the next completion
module div_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1_value,
    input  logic [XLEN-1:0] rs2_value,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t state, state_nxt;

    logic            sel_rem;
    logic            sign_q;
    logic            sign_r;
    logic [XLEN-1:0] div_mag;
    logic [XLEN-1:0] dvd;
    logic [XLEN-1:0] rem;
    logic [CW-1:0]   cnt;

    // Accept-cycle decode
    logic            is_signed;
    logic            div_zero;
    logic            ovf;
    logic            special;
    logic            accept;
    logic [XLEN-1:0] a_mag;
    logic [XLEN-1:0] b_mag;
    logic [XLEN-1:0] q_special;
    logic [XLEN-1:0] r_special;

    assign is_signed = ~funct3[0];
    assign div_zero  = (rs2_value == '0);
    assign ovf       = is_signed && (rs1_value == MIN_NEG) && (rs2_value == '1);
    assign special   = div_zero || ovf;
    assign accept    = (state == IDLE) && start && funct3[2] && !flush;

    // Negating 0x80000000 yields 0x80000000, which read unsigned is 2^31.
    assign a_mag = (is_signed && rs1_value[XLEN-1]) ? -rs1_value : rs1_value;
    assign b_mag = (is_signed && rs2_value[XLEN-1]) ? -rs2_value : rs2_value;

    assign q_special = div_zero ? '1 : MIN_NEG;
    assign r_special = div_zero ? rs1_value : '0;

    // One restoring step. The shifted partial remainder can reach 2*divisor-1,
    // so it is held at XLEN+1 bits and trial[XLEN] acts as the borrow/sign.
    logic [XLEN:0]   rem_sh;
    logic [XLEN:0]   trial;
    logic [XLEN-1:0] rem_nxt;
    logic [XLEN-1:0] dvd_nxt;
    logic [XLEN-1:0] q_fin;
    logic [XLEN-1:0] r_fin;

    assign rem_sh  = {rem, dvd[XLEN-1]};
    assign trial   = rem_sh - {1'b0, div_mag};
    assign rem_nxt = trial[XLEN] ? rem_sh[XLEN-1:0] : trial[XLEN-1:0];
    assign dvd_nxt = {dvd[XLEN-2:0], ~trial[XLEN]};
    assign q_fin   = sign_q ? -dvd_nxt : dvd_nxt;
    assign r_fin   = sign_r ? -rem_nxt : rem_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = special ? DONE : CALC;
                end
            end
            CALC: begin
                busy = 1'b1;
                if (cnt == '0) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        if (flush) begin
            state_nxt = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sel_rem <= 1'b0;
            sign_q  <= 1'b0;
            sign_r  <= 1'b0;
            div_mag <= '0;
            dvd     <= '0;
            rem     <= '0;
            cnt     <= '0;
            result  <= '0;
        end else if (!flush) begin
            if (accept) begin
                sel_rem <= funct3[1];
                sign_q  <= is_signed && (rs1_value[XLEN-1] ^ rs2_value[XLEN-1]);
                sign_r  <= is_signed && rs1_value[XLEN-1];
                div_mag <= b_mag;
                dvd     <= a_mag;
                rem     <= '0;
                cnt     <= CW'(XLEN - 1);
                if (special) begin
                    result <= funct3[1] ? r_special : q_special;
                end
            end else if (state == CALC) begin
                rem <= rem_nxt;
                dvd <= dvd_nxt;
                cnt <= cnt - CW'(1);
                if (cnt == '0) begin
                    result <= sel_rem ? r_fin : q_fin;
                end
            end
        end
    end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Multi-cycle RV32M divider in the EX stage.
- Executes DIV, DIVU, REM and REMU, and supplies the value the decoder routes to the rd write-back mux when sel_rd_value = 3.
- Raises busy so the hazard logic stalls the PC, IF/ID and ID/EX while a division is in flight.
- Abandons work when the pipeline is flushed by a taken branch or jump.

Parameters:
XLEN, 32, operand/result width; iteration count equals XLEN

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-high
start  input  1  ID/EX holds a valid M-extension divide op this cycle
funct3  input  3  100 DIV, 101 DIVU, 110 REM, 111 REMU; other codes ignored
rs1_value  input  XLEN  dividend
rs2_value  input  XLEN  divisor
flush  input  1  abort in-flight op (driven with flush_IDEX)
busy  output  1  high while state = CALC; pipeline stall request
done  output  1  one-cycle pulse, result valid
result  output  XLEN  quotient or remainder per latched funct3

Behaviour:
- Reset (rst sampled high at clk edge):
  - state = IDLE; busy = 0, done = 0, result = 0.
  - Internal quotient, remainder and counter registers are cleared.
- FSM states: IDLE, CALC, DONE.
  - IDLE -> CALC: on start with funct3[2] = 1 and no special case.
  - IDLE -> DONE: on start with a special case.
  - CALC -> DONE: after XLEN iterations.
  - DONE -> IDLE: unconditionally, after one cycle.
- Start acceptance:
  - start is sampled only in IDLE. It is ignored in CALC/DONE; the stall guarantees the op is held.
  - start with funct3[2] = 0 is ignored and the FSM stays IDLE.
- Latching at acceptance: funct3, the operands, signed = ~funct3[0], and the sign flags:
  - sign_q = rs1[XLEN-1] ^ rs2[XLEN-1]
  - sign_r = rs1[XLEN-1]
  - Both flags are forced to 0 when unsigned.
- Magnitudes: for signed ops, a negative operand is two's-complement negated. A result of 0x80000000 is treated as unsigned magnitude 2^31.
- Algorithm: radix-2 restoring division, one quotient bit per cycle.
  - Each cycle: shift {rem, dvd} left by one; trial = rem − |divisor| computed at XLEN+1 bits.
  - If trial is non-negative: rem = trial and the quotient bit = 1.
  - The counter runs from XLEN−1 down to 0; exit to DONE when it is 0.
- Finalisation, registered on the CALC -> DONE transition:
  - q = sign_q ? −q_mag : q_mag
  - r = sign_r ? −r_mag : r_mag
  - result = funct3[1] ? r : q
- Special cases resolve in the accept cycle and go directly to DONE:
  - Divisor = 0: quotient = all-ones (−1 / 0xFFFFFFFF), remainder = dividend. Applies to both signed and unsigned.
  - Signed overflow (rs1 = 0x80000000, rs2 = 0xFFFFFFFF): quotient = 0x80000000, remainder = 0.
- Latency (start accepted at edge N):
  - Normal: busy is high in cycles N+1 through N+XLEN; done is high in cycle N+XLEN+1.
  - Special case: done is high in cycle N+1 and busy never asserts.
- done / result:
  - done is high exactly when state = DONE.
  - result is updated only on entry to DONE and holds until the next completion, so the write-back mux may sample it on done.
- Flush:
  - In any state, flush forces IDLE at the next edge; busy and done drop and no done pulse is produced.
  - result keeps its prior value.
  - flush and start in the same cycle: flush wins and the op is not accepted.
  - flush in DONE: the done already visible this cycle stands; the FSM returns to IDLE as normal.
- Back-to-back ops: the next op may be accepted in the first IDLE cycle after DONE, so minimum spacing is XLEN+2 cycles.
- rst mid-operation: same effect as reset; the in-flight op is lost and result = 0.

Test Plan:
- DIVU 100 / 7, start held 1 cycle -> busy for 32 cycles; done in cycle N+33; result = 14. Repeat as REMU -> result = 2.
- DIV −7 (0xFFFFFFF9) / 2 -> result = 0xFFFFFFFD (−3). REM with the same operands -> 0xFFFFFFFF (−1). REM 7 / −2 -> 1.
- DIV 5 / 0 -> done at N+1 with result 0xFFFFFFFF and busy never high. REMU 5 / 0 -> result = 5.
- DIV 0x80000000 / 0xFFFFFFFF -> done at N+1, result = 0x80000000. REM with the same operands -> 0. DIVU with the same operands -> 32-cycle run, result = 0.
- Start DIVU 1000 / 3, assert flush in CALC cycle 10 -> next cycle IDLE, busy = 0, no done pulse, result unchanged from the previous op. A fresh DIVU 9 / 3 then completes with result 3. Also flush and start in the same cycle -> no acceptance.
- start with funct3 = 000 -> remains IDLE, busy and done stay 0. Assert rst during CALC -> next cycle busy = 0, done = 0, result = 0.
